// File: rtl/serdes_rx_deframer.sv
// Receive deframer: locks on idle commas, packs SOF-delimited bytes (LSB first)
// into LOGIC_SIZE-bit words and presents them through a 2-entry AXIS buffer.
module serdes_rx_deframer #(
  parameter int          LOGIC_SIZE = 32,
  parameter int          LOCK_IDLES = 4,
  parameter logic [7:0]  K_IDLE     = 8'hBC,
  parameter logic [7:0]  K_SOF      = 8'hFB
) (
  input  logic                  s_axis_aclk,
  input  logic                  s_axis_reset_n,
  input  logic [7:0]            i_from_decoder,
  input  logic                  i_k,
  input  logic                  i_code_err,
  input  logic                  i_sym_valid,
  output logic [LOGIC_SIZE-1:0] s_axis_tdata,
  output logic                  s_axis_valid,
  input  logic                  s_axis_ready,
  output logic                  o_locked,
  output logic [7:0]            o_frame_err_cnt,
  output logic [7:0]            o_overflow_cnt
);

  localparam int NB    = LOGIC_SIZE / 8;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
  localparam int RUN_W = $clog2(LOCK_IDLES + 1);

  typedef enum logic [1:0] {HUNT, IDLE, DATA} state_t;

  state_t                state, state_nxt;
  logic [RUN_W-1:0]      run, run_nxt;
  logic [IDX_W-1:0]      idx, idx_nxt;
  logic                  ferr_evt;
  logic                  push;
  logic                  lane_wr;
  logic [LOGIC_SIZE-1:0] acc;
  logic [LOGIC_SIZE-1:0] word_nxt;

  logic [LOGIC_SIZE-1:0] mem [0:1];
  logic                  wr_ptr, rd_ptr;
  logic [1:0]            count;
  logic                  pop, push_ok, ovf_evt;

  function automatic logic [7:0] sat_inc(input logic [7:0] cnt, input logic ev);
    if (ev && (cnt != 8'hFF)) return cnt + 8'd1;
    return cnt;
  endfunction

  // Symbol decode / framing FSM
  always_comb begin
    state_nxt = state;
    run_nxt   = run;
    idx_nxt   = idx;
    ferr_evt  = 1'b0;
    push      = 1'b0;
    lane_wr   = 1'b0;
    if (i_sym_valid) begin
      unique case (state)
        HUNT: begin
          if (i_k && !i_code_err && (i_from_decoder == K_IDLE)) begin
            if (run == RUN_W'(LOCK_IDLES - 1)) begin
              state_nxt = IDLE;
              run_nxt   = '0;
            end else begin
              run_nxt = run + RUN_W'(1);
            end
          end else begin
            run_nxt = '0;
          end
        end
        IDLE: begin
          if (i_code_err) begin
            state_nxt = HUNT;
            run_nxt   = '0;
          end else if (i_k && (i_from_decoder == K_IDLE)) begin
            state_nxt = IDLE;
          end else if (i_k && (i_from_decoder == K_SOF)) begin
            state_nxt = DATA;
            idx_nxt   = '0;
          end else begin
            ferr_evt = 1'b1;
          end
        end
        DATA: begin
          if (i_code_err || i_k) begin
            ferr_evt  = 1'b1;
            state_nxt = HUNT;
            run_nxt   = '0;
            idx_nxt   = '0;
          end else begin
            lane_wr = 1'b1;
            if (idx == IDX_W'(NB - 1)) begin
              push      = 1'b1;
              state_nxt = IDLE;
              idx_nxt   = '0;
            end else begin
              idx_nxt = idx + IDX_W'(1);
            end
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  // Completed word: accumulated lanes with the current byte merged in
  always_comb begin
    word_nxt = acc;
    word_nxt[idx*8 +: 8] = i_from_decoder;
  end

  assign s_axis_valid = (count != 2'd0);
  assign pop          = s_axis_valid && s_axis_ready;
  assign push_ok      = push && ((count != 2'd2) || pop);
  assign ovf_evt      = push && !push_ok;
  assign s_axis_tdata = mem[rd_ptr];
  assign o_locked     = (state != HUNT);

  always_ff @(posedge s_axis_aclk or negedge s_axis_reset_n) begin
    if (!s_axis_reset_n) begin
      state           <= HUNT;
      run             <= '0;
      idx             <= '0;
      o_frame_err_cnt <= '0;
    end else begin
      state           <= state_nxt;
      run             <= run_nxt;
      idx             <= idx_nxt;
      o_frame_err_cnt <= sat_inc(o_frame_err_cnt, ferr_evt);
    end
  end

  // Partial-word lanes carry no control meaning and need no reset
  always_ff @(posedge s_axis_aclk) begin
    if (lane_wr) acc <= word_nxt;
  end

  // Output buffer: storage is cleared so tdata reads zero out of reset
  always_ff @(posedge s_axis_aclk or negedge s_axis_reset_n) begin
    if (!s_axis_reset_n) begin
      mem[0]         <= '0;
      mem[1]         <= '0;
      wr_ptr         <= 1'b0;
      rd_ptr         <= 1'b0;
      count          <= 2'd0;
      o_overflow_cnt <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= word_nxt;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      unique case ({push_ok, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      o_overflow_cnt <= sat_inc(o_overflow_cnt, ovf_evt);
    end
  end

endmodule

// File: tb/tb_serdes_rx_deframer.sv
// Directed bench for serdes_rx_deframer: lock, framing, errors, buffering, reset.
module tb_serdes_rx_deframer;

  localparam logic [7:0] K_IDLE = 8'hBC;
  localparam logic [7:0] K_SOF  = 8'hFB;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  sym;
  logic        k, err, sv;
  logic [31:0] tdata;
  logic        valid, ready, locked;
  logic [7:0]  ferr, ovf;

  int checks = 0;
  int errors = 0;

  serdes_rx_deframer #(.LOGIC_SIZE(32), .LOCK_IDLES(4), .K_IDLE(8'hBC), .K_SOF(8'hFB)) dut (
    .s_axis_aclk     (clk),
    .s_axis_reset_n  (rst_n),
    .i_from_decoder  (sym),
    .i_k             (k),
    .i_code_err      (err),
    .i_sym_valid     (sv),
    .s_axis_tdata    (tdata),
    .s_axis_valid    (valid),
    .s_axis_ready    (ready),
    .o_locked        (locked),
    .o_frame_err_cnt (ferr),
    .o_overflow_cnt  (ovf)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    rst_n = 1'b0; sv = 1'b0; k = 1'b0; err = 1'b0; sym = 8'h00; ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic send(input logic [7:0] b, input logic kk, input logic e);
    @(negedge clk);
    sym = b; k = kk; err = e; sv = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Strobe low with junk on the symbol lines; must be ignored
  task automatic gap();
    @(negedge clk);
    sv = 1'b0; sym = 8'hFF; k = 1'b1; err = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic lock_up();
    repeat (4) send(K_IDLE, 1'b1, 1'b0);
  endtask

  task automatic send_word(input logic [31:0] w);
    send(K_SOF, 1'b1, 1'b0);
    for (int j = 0; j < 4; j++) send(w[j*8 +: 8], 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid); end
    checks++; if (tdata !== 32'h0) begin errors++; $display("FAIL reset_tdata got %h exp 0", tdata); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %b exp 0", locked); end
    checks++; if (ferr !== 8'h00 || ovf !== 8'h00) begin errors++; $display("FAIL reset_cnt got %h/%h exp 00/00", ferr, ovf); end
  endtask

  task automatic test_basic_word();
    do_reset();
    repeat (3) send(K_IDLE, 1'b1, 1'b0);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL basic_lock3 got %b exp 0", locked); end
    send(K_IDLE, 1'b1, 1'b0);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL basic_lock4 got %b exp 1", locked); end
    send(K_SOF, 1'b1, 1'b0);
    send(8'h78, 1'b0, 1'b0);
    send(8'h56, 1'b0, 1'b0);
    gap(); gap();
    send(8'h34, 1'b0, 1'b0);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %b exp 0", valid); end
    send(8'h12, 1'b0, 1'b0);
    checks++; if (valid !== 1'b1 || tdata !== 32'h12345678) begin
      errors++; $display("FAIL basic_word got %b/%h exp 1/12345678", valid, tdata); end
    gap();
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL basic_one_cycle got %b exp 0", valid); end
    checks++; if (ferr !== 8'h00 || ovf !== 8'h00) begin errors++; $display("FAIL basic_cnt got %h/%h exp 00/00", ferr, ovf); end
  endtask

  task automatic test_hunt_break();
    do_reset();
    repeat (3) send(K_IDLE, 1'b1, 1'b0);
    send(8'h55, 1'b0, 1'b0);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL hunt_break got %b exp 0", locked); end
    repeat (3) send(K_IDLE, 1'b1, 1'b0);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL hunt_rerun3 got %b exp 0", locked); end
    send(K_IDLE, 1'b1, 1'b0);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL hunt_rerun4 got %b exp 1", locked); end
    checks++; if (ferr !== 8'h00) begin errors++; $display("FAIL hunt_ferr got %h exp 00", ferr); end
  endtask

  task automatic test_frame_abort();
    do_reset();
    lock_up();
    send(K_SOF, 1'b1, 1'b0);
    send(8'hAA, 1'b0, 1'b0);
    send(8'hBB, 1'b0, 1'b0);
    send(K_IDLE, 1'b1, 1'b0);
    checks++; if (ferr !== 8'h01) begin errors++; $display("FAIL abort_ferr got %h exp 01", ferr); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL abort_locked got %b exp 0", locked); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL abort_valid got %b exp 0", valid); end
    lock_up();
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL abort_relock got %b exp 1", locked); end
    send(8'h99, 1'b0, 1'b0);
    checks++; if (ferr !== 8'h02) begin errors++; $display("FAIL idle_data_err got %h exp 02", ferr); end
  endtask

  task automatic test_overflow();
    do_reset();
    lock_up();
    ready = 1'b0;
    send_word(32'h11111111);
    send_word(32'h22222222);
    send_word(32'h33333333);
    checks++; if (ovf !== 8'h01) begin errors++; $display("FAIL ovf_cnt got %h exp 01", ovf); end
    for (int c = 0; c < 3; c++) begin
      gap();
      checks++; if (valid !== 1'b1 || tdata !== 32'h11111111) begin
        errors++; $display("FAIL ovf_stall got %b/%h exp 1/11111111", valid, tdata); end
    end
    @(negedge clk) ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (valid !== 1'b1 || tdata !== 32'h22222222) begin
      errors++; $display("FAIL ovf_second got %b/%h exp 1/22222222", valid, tdata); end
    @(posedge clk); #1;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL ovf_drained got %b exp 0", valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w;
    do_reset();
    lock_up();
    for (int i = 0; i < 10; i++) begin
      w = 32'h03020100 + i * 32'h04040404;
      send_word(w);
      checks++; if (valid !== 1'b1 || tdata !== w) begin
        errors++; $display("FAIL b2b_word%0d got %b/%h exp 1/%h", i, valid, tdata, w); end
    end
    gap();
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b exp 0", valid); end
    checks++; if (ferr !== 8'h00 || ovf !== 8'h00) begin errors++; $display("FAIL b2b_cnt got %h/%h exp 00/00", ferr, ovf); end
  endtask

  task automatic test_code_err_reset();
    do_reset();
    lock_up();
    send(K_SOF, 1'b1, 1'b0);
    send(8'h01, 1'b0, 1'b0);
    send(8'h02, 1'b0, 1'b0);
    send(8'h03, 1'b0, 1'b1);
    checks++; if (ferr !== 8'h01 || locked !== 1'b0) begin
      errors++; $display("FAIL cerr_state got %h/%b exp 01/0", ferr, locked); end
    lock_up();
    ready = 1'b0;
    send_word(32'hCAFEF00D);
    checks++; if (valid !== 1'b1 || tdata !== 32'hCAFEF00D) begin
      errors++; $display("FAIL cerr_buffered got %b/%h exp 1/cafef00d", valid, tdata); end
    send(K_SOF, 1'b1, 1'b0);
    send(8'h44, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (valid !== 1'b0 || tdata !== 32'h0) begin
      errors++; $display("FAIL async_rst_out got %b/%h exp 0/0", valid, tdata); end
    checks++; if (locked !== 1'b0 || ferr !== 8'h00 || ovf !== 8'h00) begin
      errors++; $display("FAIL async_rst_ctl got %b/%h/%h exp 0/00/00", locked, ferr, ovf); end
    sv = 1'b0;
    @(negedge clk) rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic_word();
    test_hunt_break();
    test_frame_abort();
    test_overflow();
    test_back_to_back();
    test_code_err_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
